sequential_ripple_borrow_subtract: RTL and testbench
====================================================

SEQUENTIAL_RIPPLE_BORROW_SUBTRACT -- requirements
Module: sequential_ripple_borrow_subtract

Interface
REQ-001 SHALL have parameter N, default 32: datapath width in bits.
REQ-002 SHALL have parameter W, default 8: digit width processed per cycle.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operands a, b and bi are valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port a, input, N: minuend.
REQ-008 SHALL have port b, input, N: subtrahend.
REQ-009 SHALL have port bi, input, 1: borrow in.
REQ-010 SHALL have port out_valid, output, 1: result valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port c, output, N: difference a - b - bi, modulo 2^N.
REQ-013 SHALL have port bo, output, 1: borrow out; 1 iff a < b + bi as unsigned values.
REQ-014 SHALL have port ov, output, 1: signed overflow.

Function
REQ-015 SHALL fail elaboration unless N % W == 0 and 1 <= W <= N.
REQ-016 SHALL implement three states: IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-018 SHALL accept on a rising edge with in_valid && in_ready: latch a, b and bi, clear digit counter, clear c, go to RUN.
REQ-019 SHALL, in RUN, process digit k (bits k*W+W-1 : k*W) per cycle, LSB digit first, with a registered running borrow seeded from bi.
REQ-020 SHALL, per digit: diff = a_k - b_k - borrow over W+1 bits; c digit k = diff[W-1:0]; next borrow = diff[W].
REQ-021 SHALL, after the digit at k = N/W-1: set bo = final borrow; set ov = (a[N-1] != b[N-1]) && (c[N-1] != a[N-1]); go to DONE.
REQ-022 SHALL assert out_valid exactly N/W cycles after the accept edge (W = N gives 1 cycle).
REQ-023 SHALL hold c, bo and ov stable throughout DONE, regardless of input activity.
REQ-024 SHALL complete the result transfer on a rising edge with out_valid && out_ready, then return to IDLE; there is no accept on that same edge.
REQ-025 SHALL keep c, bo and ov at the last result in IDLE until the next accept.
REQ-026 SHALL ignore in_valid, a, b and bi outside IDLE; latched operands are unaffected by input changes during RUN or DONE.
REQ-027 SHALL give a pure wrap-around result; there is no saturation.

Reset
REQ-028 SHALL, while rst = 1, immediately force state IDLE, in_ready = 0, out_valid = 0, c = 0, bo = 0, ov = 0, and clear the counter and internal borrow.
REQ-029 SHALL drive in_ready = 1 from the first clock edge after rst deasserts.
REQ-030 SHALL abort any RUN or DONE operation on reset; the aborted result is never presented.

Verification (N=32, W=8)
REQ-031 SHALL cover basic subtraction: a=5, b=3, bi=0 accepted -> out_valid high 4 cycles later; c=0x00000002, bo=0, ov=0.
REQ-032 SHALL cover underflow: a=0, b=1, bi=0 -> c=0xFFFFFFFF, bo=1, ov=0. Separately, a=b=0x00001234, bi=1 -> c=0xFFFFFFFF, bo=1.
REQ-033 SHALL cover signed overflow: a=0x80000000, b=1 -> c=0x7FFFFFFF, bo=0, ov=1. Separately, a=0x7FFFFFFF, b=0xFFFFFFFF -> c=0x80000000, bo=1, ov=1.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles in DONE, with new in_valid and operands toggling -> out_valid, c, bo and ov stay stable and in_ready=0. Raising out_ready gives one transfer, then IDLE with in_ready=1.
REQ-035 SHALL cover reset mid-operation: rst pulsed in the 2nd RUN cycle -> outputs zero at once and out_valid never rises for that operation. A fresh a=10, b=4 then yields c=6 after 4 cycles.
REQ-036 SHALL cover back-to-back operations: continuous in_valid with out_ready=1 -> one result per 6 cycles (accept, 4 RUN, DONE), results in order with correct values.

Source files
------------

// File: rtl/sequential_ripple_borrow_subtract.sv
// -----------------------------------------------------------------------------
// sequential_ripple_borrow_subtract
//
// Multi-cycle subtractor: computes c = a - b - bi (mod 2^N) one W-bit digit per
// clock, least-significant digit first, rippling a registered borrow between
// digits. A result takes N/W cycles after the accept edge and is then held
// until the consumer takes it.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   a, b, bi are valid
//   in_ready   out  block can accept operands (IDLE only)
//   a          in   N-bit minuend
//   b          in   N-bit subtrahend
//   bi         in   borrow in
//   out_valid  out  c, bo, ov are valid (DONE only)
//   out_ready  in   consumer accepts the result
//   c          out  N-bit difference
//   bo         out  unsigned borrow out
//   ov         out  signed overflow
// -----------------------------------------------------------------------------
module sequential_ripple_borrow_subtract #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         bo,
    output logic         ov
);

    localparam int ND = N / ((W < 1) ? 1 : W);
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Reject unsupported digit widths at elaboration.
    generate
        if ((W < 1) || (W > N) || ((N % ((W < 1) ? 1 : W)) != 0)) begin : g_bad_params
            $error("sequential_ripple_borrow_subtract: N must be a multiple of W and 1 <= W <= N");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic          armed_q;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          borrow_q, borrow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  c_q, c_d;
    logic          bo_q, bo_d;
    logic          ov_q, ov_d;

    // Digit selection: digit tables padded to a power of two so the counter
    // can index them directly without out-of-range entries.
    logic [W-1:0] a_digits [0:(1<<CW)-1];
    logic [W-1:0] b_digits [0:(1<<CW)-1];
    logic [W-1:0] a_dig;
    logic [W-1:0] b_dig;
    logic [W:0]   diff;
    logic [N-1:0] c_run;
    logic         last_digit;

    genvar gi;
    generate
        for (gi = 0; gi < (1 << CW); gi++) begin : g_digit_tbl
            if (gi < ND) begin : g_real
                assign a_digits[gi] = a_q[gi*W +: W];
                assign b_digits[gi] = b_q[gi*W +: W];
            end else begin : g_pad
                assign a_digits[gi] = '0;
                assign b_digits[gi] = '0;
            end
        end

        // Result vector with the current digit replaced by this cycle's difference.
        for (gi = 0; gi < ND; gi++) begin : g_c_write
            assign c_run[gi*W +: W] = (cnt_q == CW'(gi)) ? diff[W-1:0] : c_q[gi*W +: W];
        end
    endgenerate

    assign a_dig      = a_digits[cnt_q];
    assign b_dig      = b_digits[cnt_q];
    // Top bit of the W+1-bit result is the borrow out of this digit.
    assign diff       = {1'b0, a_dig} - {1'b0, b_dig} - {{W{1'b0}}, borrow_q};
    assign last_digit = (cnt_q == CW'(ND - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        bo_d     = bo_q;
        ov_d     = ov_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bi;
                    cnt_d    = '0;
                    c_d      = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                c_d      = c_run;
                borrow_d = diff[W];
                cnt_d    = cnt_q + CW'(1);
                if (last_digit) begin
                    bo_d    = diff[W];
                    // diff[W-1] is the sign bit of the finished result.
                    ov_d    = (a_q[N-1] != b_q[N-1]) && (diff[W-1] != a_q[N-1]);
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            armed_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            c_q      <= '0;
            bo_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            // in_ready stays low until the first edge after reset release.
            armed_q  <= 1'b1;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            bo_q     <= bo_d;
            ov_q     <= ov_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && armed_q;
    assign out_valid = (state_q == ST_DONE);
    assign c         = c_q;
    assign bo        = bo_q;
    assign ov        = ov_q;

endmodule

// File: tb/tb_sequential_ripple_borrow_subtract.sv
// -----------------------------------------------------------------------------
// Testbench for sequential_ripple_borrow_subtract (N=32, W=8).
// Directed cases plus random operands checked against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_sequential_ripple_borrow_subtract;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic        bo;
    logic        ov;

    int tests_run;
    int tests_failed;

    sequential_ripple_borrow_subtract #(.N(32), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .bo        (bo),
        .ov        (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic mbi,
                                  output logic [31:0] mc, output logic mbo, output logic mov);
        longint sa, sb, sbi, sr;
        longint ua, ub;
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        sbi = longint'(mbi);
        ua  = longint'(ma);
        ub  = longint'(mb);
        sr  = sa - sb - sbi;
        mc  = 32'(ua - ub - sbi);
        mbo = (ua < ub + sbi);
        mov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction

    // Presents one operation in IDLE, waits for the result, then takes it.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbi,
                         output int lat, output logic [31:0] rc, output logic rbo, output logic rov);
        a = ta; b = tb_v; bi = tbi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rc = c; rbo = bo; rov = ov;
        $display("[TB] op a=%08h b=%08h bi=%0d -> c=%08h bo=%0d ov=%0d lat=%0d", ta, tb_v, tbi, rc, rbo, rov, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bi = 1'b0;
        #12;
        tests_run++;
        if ({in_ready, out_valid, c, bo, ov} !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%0d vld=%0d c=%08h bo=%0d ov=%0d, want all 0", in_ready, out_valid, c, bo, ov);
        end
        #10 rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %0d want 0 before first edge", in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: got %0d want 1", in_ready);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'd5, 32'd0, 32'h00001234, 32'h80000000, 32'h7FFFFFFF, 32'd10};
        logic [31:0] tb_v [6] = '{32'd3, 32'd1, 32'h00001234, 32'd1, 32'hFFFFFFFF, 32'd4};
        logic        tbi [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ec [6] = '{32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h6};
        logic        ebo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        eov [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        logic [31:0] rc;
        logic rbo, rov;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb_v[i], tbi[i], lat, rc, rbo, rov);
            tests_run++;
            if (lat !== 4) begin
                tests_failed++;
                $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat);
            end
            tests_run++;
            if ({rc, rbo, rov} !== {ec[i], ebo[i], eov[i]}) begin
                tests_failed++;
                $display("FAIL directed_result[%0d]: got c=%08h bo=%0d ov=%0d want c=%08h bo=%0d ov=%0d",
                         i, rc, rbo, rov, ec[i], ebo[i], eov[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] ra, rb, rc, mc;
        logic rbi, rbo, rov, mbo, mov;
        for (int i = 0; i < 30; i++) begin
            ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
            if (i % 5 == 0) rb = ra;
            model(ra, rb, rbi, mc, mbo, mov);
            do_op(ra, rb, rbi, lat, rc, rbo, rov);
            tests_run++;
            if ({rc, rbo, rov, lat} !== {mc, mbo, mov, 32'd4}) begin
                tests_failed++;
                $display("FAIL random[%0d]: got c=%08h bo=%0d ov=%0d lat=%0d want c=%08h bo=%0d ov=%0d lat=4",
                         i, rc, rbo, rov, lat, mc, mbo, mov);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] mc;
        logic mbo, mov;
        int waited;
        a = 32'h0F0F0001; b = 32'h10000002; bi = 1'b1;
        model(a, b, bi, mc, mbo, mov);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            @(posedge clk); #1;
            tests_run++;
            if ({out_valid, in_ready, c, bo, ov} !== {1'b1, 1'b0, mc, mbo, mov}) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: got vld=%0d rdy=%0d c=%08h bo=%0d ov=%0d want vld=1 rdy=0 c=%08h bo=%0d ov=%0d",
                         i, out_valid, in_ready, c, bo, ov, mc, mbo, mov);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if ({out_valid, in_ready, c, bo, ov} !== {1'b0, 1'b1, mc, mbo, mov}) begin
            tests_failed++;
            $display("FAIL backpressure_release: got vld=%0d rdy=%0d c=%08h bo=%0d ov=%0d want vld=0 rdy=1 c=%08h bo=%0d ov=%0d",
                     out_valid, in_ready, c, bo, ov, mc, mbo, mov);
        end
        $display("[TB] backpressure transfer c=%08h bo=%0d ov=%0d", c, bo, ov);
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [31:0] rc;
        logic rbo, rov;
        a = 32'h12345678; b = 32'h00000001; bi = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, out_valid, c, bo, ov} !== 35'd0) begin
            tests_failed++;
            $display("FAIL midop_reset_outputs: got rdy=%0d vld=%0d c=%08h bo=%0d ov=%0d want all 0", in_ready, out_valid, c, bo, ov);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL midop_no_result[%0d]: got out_valid=%0d want 0", i, out_valid);
            end
        end
        $display("[TB] reset mid-op done");
        do_op(32'd10, 32'd4, 1'b0, lat, rc, rbo, rov);
        tests_run++;
        if ({rc, rbo, rov, lat} !== {32'd6, 1'b0, 1'b0, 32'd4}) begin
            tests_failed++;
            $display("FAIL after_reset_op: got c=%08h bo=%0d ov=%0d lat=%0d want c=6 bo=0 ov=0 lat=4", rc, rbo, rov, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] exp_q [$];
        logic [64:0] head;
        logic [31:0] mc;
        logic mbo, mov;
        int issued, got, last_cyc;
        bit pending;
        issued = 0; got = 0; last_cyc = 0; pending = 0;
        a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
            if (out_valid) begin
                head = exp_q.pop_front();
                model(head[64:33], head[32:1], head[0], mc, mbo, mov);
                $display("[TB] b2b result %0d c=%08h bo=%0d ov=%0d", got, c, bo, ov);
                tests_run++;
                if ({c, bo, ov} !== {mc, mbo, mov}) begin
                    tests_failed++;
                    $display("FAIL b2b_result[%0d]: got c=%08h bo=%0d ov=%0d want c=%08h bo=%0d ov=%0d", got, c, bo, ov, mc, mbo, mov);
                end
                if (got > 0) begin
                    tests_run++;
                    if (cyc - last_cyc !== 6) begin
                        tests_failed++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles want 6", got, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            if (in_ready && issued < 5) begin
                exp_q.push_back({a, b, bi});
                issued++;
                pending = 1;
            end
            @(posedge clk); #1;
            if (pending) begin
                pending = 0;
                if (issued == 5) in_valid = 1'b0;
                else begin
                    a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (got !== 5) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results want 5", got);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
